// File: rtl/seq_pattern_pkg.sv
// seq_pattern_pkg
//   Shared definitions for the serial pattern link: transmitter FSM state
//   encoding and the default pattern (also used by the 10111 detector bench).
package seq_pattern_pkg;

  // One-hot transmitter states
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SHIFT = 4'b0010,
    ST_GAP   = 4'b0100,
    ST_DONE  = 4'b1000
  } tx_state_t;

  localparam int         DEF_PAT_W = 5;
  localparam logic [4:0] DEF_PAT   = 5'b10111;

endpackage

// File: rtl/seq_down_cnt.sv
// seq_down_cnt
//   Loadable down-counter with a zero flag. Load has priority over
//   decrement; decrement saturates at zero.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (clears count)
//   load        - load load_val this edge
//   load_val    - value to load
//   dec         - decrement this edge (ignored when count is zero)
//   cnt         - current count
//   zero        - count equals zero
module seq_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
//   Bit-serial pattern transmitter. On an accepted start, emits PAT MSB-first
//   one bit per clock, repeated rep_cnt times (0 treated as 1) with GAP idle
//   cycles between repetitions, then pulses done for one cycle.
// Optional feature (macro SEQ_TX_ABORT_EN): adds input abort; abort sampled in
//   SHIFT or GAP ends the transfer through DONE, discarding remaining reps.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - start request, sampled only in IDLE
//   rep_cnt    - repetition count, latched when start is accepted
//   abort      - (SEQ_TX_ABORT_EN only) abandon transfer
//   data       - serial bit, 0 whenever data_vld=0
//   data_vld   - data carries a pattern bit
//   busy       - transfer in progress
//   done       - one-cycle pulse after the last bit
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int               PAT_W = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT   = DEF_PAT,
  parameter int               GAP   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] rep_cnt,
`ifdef SEQ_TX_ABORT_EN
  input  logic       abort,
`endif
  output logic       data,
  output logic       data_vld,
  output logic       busy,
  output logic       done
);

  localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  tx_state_t state;

  logic          abort_hit;
  logic          bit_load, bit_dec, bit_zero;
  logic [BW-1:0] bit_cnt;
  logic          gap_load, gap_dec, gap_zero;
  logic [3:0]    gap_cnt;
  logic          rep_load, rep_dec, rep_zero;
  logic [7:0]    rep_left;
  logic [7:0]    rep_load_val;
  logic [3:0]    gap_load_val;
  logic          unused_cnt_bits;

`ifdef SEQ_TX_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // bit_cnt holds the index of the bit currently on data; rep_left holds the
  // repetitions still to send after the current one, so zero at the last
  // bit means the transfer is finishing.
  assign rep_load_val = (rep_cnt == 8'd0) ? 8'd0 : rep_cnt - 8'd1;
  assign gap_load_val = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  always_comb begin
    bit_load = 1'b0;
    bit_dec  = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    rep_load = 1'b0;
    rep_dec  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        bit_load = start;
        rep_load = start;
      end
      ST_SHIFT: begin
        bit_dec  = !bit_zero;
        rep_dec  = bit_zero;
        gap_load = bit_zero;
        bit_load = bit_zero && (GAP == 0);
      end
      ST_GAP: begin
        gap_dec  = 1'b1;
        bit_load = gap_zero;
      end
      default: ;
    endcase
  end

  seq_down_cnt #(.W(BW)) u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (bit_load),
    .load_val (BW'(PAT_W - 1)),
    .dec      (bit_dec),
    .cnt      (bit_cnt),
    .zero     (bit_zero)
  );

  seq_down_cnt #(.W(4)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (gap_load_val),
    .dec      (gap_dec),
    .cnt      (gap_cnt),
    .zero     (gap_zero)
  );

  seq_down_cnt #(.W(8)) u_rep_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rep_load),
    .load_val (rep_load_val),
    .dec      (rep_dec),
    .cnt      (rep_left),
    .zero     (rep_zero)
  );

  assign unused_cnt_bits = ^{gap_cnt, rep_left};

  // Outputs are registered alongside the state so that in any cycle they
  // reflect the state and counters of that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      data     <= 1'b0;
      data_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SHIFT;
            data     <= PAT[PAT_W-1];
            data_vld <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (abort_hit || (bit_zero && rep_zero)) begin
            state    <= ST_DONE;
            data     <= 1'b0;
            data_vld <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else if (!bit_zero) begin
            data <= PAT[bit_cnt - BW'(1)];
          end else if (GAP == 0) begin
            data <= PAT[PAT_W-1];
          end else begin
            state    <= ST_GAP;
            data     <= 1'b0;
            data_vld <= 1'b0;
          end
        end
        ST_GAP: begin
          if (abort_hit) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (gap_zero) begin
            state    <= ST_SHIFT;
            data     <= PAT[PAT_W-1];
            data_vld <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          data     <= 1'b0;
          data_vld <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx
//   Self-checking bench for seq_pattern_tx with default parameters
//   (10111, width 5, gap 2). Expected outputs come from a cycle-indexed
//   model of the transfer; a sliding 5-bit window stands in for the
//   downstream 10111 detector.
module tb_seq_pattern_tx;
  import seq_pattern_pkg::*;

  localparam int            PW    = DEF_PAT_W;
  localparam int            GP    = 2;
  localparam logic [PW-1:0] PAT_V = DEF_PAT;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [7:0] rep_cnt;
  logic       data, data_vld, busy, done;

  int checks   = 0;
  int failures = 0;
  logic [PW-1:0] hist;
  int            hits;

  always #5 clk = ~clk;

  seq_pattern_tx #(.PAT_W(PW), .PAT(PAT_V), .GAP(GP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rep_cnt  (rep_cnt),
`ifdef SEQ_TX_ABORT_EN
    .abort    (abort),
`endif
    .data     (data),
    .data_vld (data_vld),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {28'b0, data_vld, data, busy, done};
  endfunction

  // Expected {data_vld, data, busy, done} in cycle k after start was sampled
  // at the end of cycle 0, for an effective repetition count n.
  function automatic logic [31:0] exp_out(input int k, input int n);
    int total;
    int pos;
    total = n * PW + (n - 1) * GP;
    if (k >= 1 && k <= total) begin
      pos = (k - 1) % (PW + GP);
      if (pos < PW) return {28'b0, 1'b1, PAT_V[PW-1-pos], 1'b1, 1'b0};
      return 32'b0010;
    end
    if (k == total + 1) return 32'b0001;
    return 32'b0000;
  endfunction

  task automatic detect();
    hist = {hist[PW-2:0], data};
    if (hist == PAT_V) hits++;
  endtask

  // Called at a negedge. Runs one full transfer; with noise, start and
  // rep_cnt toggle randomly while busy. A start in the DONE cycle is
  // always applied and must be ignored.
  task automatic do_transfer(input int rep_in, input bit noise);
    int n;
    int total;
    int h0;
    n     = (rep_in == 0) ? 1 : rep_in;
    total = n * PW + (n - 1) * GP;
    h0    = hits;
    start   = 1'b1;
    rep_cnt = 8'(rep_in);
    for (int k = 1; k <= total + 2; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (noise && k <= total) begin
        start   = 1'($urandom_range(0, 1));
        rep_cnt = 8'($urandom);
      end
      if (k == total + 1) start = 1'b1;
      detect();
      chk($sformatf("out rep%0d cyc%0d", rep_in, k), outs(), exp_out(k, n));
    end
    start = 1'b0;
    chk($sformatf("det_hits rep%0d", rep_in), 32'(hits - h0), 32'(n));
  endtask

  initial begin
    int h0;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    rep_cnt = 8'd0;
    hist    = '0;
    hits    = 0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_reset", outs(), 32'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_after_reset", outs(), 32'b0);
    end

    do_transfer(1, 1'b0);
    do_transfer(2, 1'b0);
    do_transfer(0, 1'b1);

    // Reset in cycle 3 of a three-repetition transfer
    start   = 1'b1;
    rep_cnt = 8'd3;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      detect();
      chk($sformatf("pre_rst cyc%0d", k), outs(), exp_out(k, 3));
    end
    #1 rst_n = 1'b0;
    #1 chk("async_rst", outs(), 32'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      detect();
      chk("post_rst_idle", outs(), 32'b0);
    end
    do_transfer(1, 1'b0);

    do_transfer(4, 1'b0);

    for (int t = 0; t < 6; t++) begin
      do_transfer(int'($urandom_range(0, 5)), 1'b1);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        detect();
        chk("idle_between", outs(), 32'b0);
      end
    end

`ifdef SEQ_TX_ABORT_EN
    // abort ignored while idle
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", outs(), 32'b0);
    // abort sampled during the 2nd bit
    h0      = hits;
    start   = 1'b1;
    rep_cnt = 8'd3;
    @(negedge clk);
    start = 1'b0;
    detect();
    chk("abort_bit1", outs(), exp_out(1, 3));
    @(negedge clk);
    detect();
    chk("abort_bit2", outs(), exp_out(2, 3));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    detect();
    chk("abort_done", outs(), 32'b0001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      detect();
      chk("abort_after", outs(), 32'b0);
    end
    chk("abort_det_hits", 32'(hits - h0), 32'd0);
`else
    h0 = hits;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Bit-serial pattern transmitter: on a start request, emits a fixed PAT_W-bit pattern MSB-first, one bit per clock, repeated a requested number of times with idle gaps between repetitions.
- It is the transmit end of the serial pattern link whose receive end is the existing 10111 sequence detector.
- Used as the stimulus source and loopback partner for that detector.

Parameters:
- PAT_W, 5, pattern length in bits (2..32).
- PAT, 5'b10111, pattern value; bit PAT_W-1 is transmitted first.
- GAP, 2, idle cycles inserted between repetitions (0..15); GAP=0 means back-to-back repetitions.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, start request; sampled only in IDLE.
- rep_cnt, input, 8, number of repetitions; latched when start is accepted; 0 is treated as 1.
- data, output, 1, serial bit; forced to 0 whenever data_vld=0.
- data_vld, output, 1, data holds a pattern bit this cycle.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, single-cycle pulse after the last bit of the last repetition.

Behaviour:
- All outputs are registered.
- Reset value: data=0, data_vld=0, busy=0, done=0. State goes to IDLE and counters clear immediately, asynchronously.
- One-hot FSM states: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - If start=1 at the edge, latch the repetition count (rep_cnt, or 1 if rep_cnt=0), load the pattern, and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - data=PAT[PAT_W-1-i] and data_vld=1 for i=0..PAT_W-1.
  - The first bit appears in the cycle after start is sampled (latency 1).
  - After bit PAT_W-1, decrement the remaining repetition count.
  - If the remaining count is 0, go to DONE.
  - Else, if GAP>0, go to GAP.
  - Else (GAP=0), reload and continue in SHIFT with no bubble.
- GAP: data=0 and data_vld=0 for exactly GAP cycles, then reload and go to SHIFT.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE. A start in the DONE cycle is ignored; the earliest accepted start is sampled in the first IDLE cycle.
- A start asserted while busy is ignored and is not queued.
- Changes to rep_cnt while busy are ignored.
- Bit counter width is clog2(PAT_W). Gap counter is 4 bits. Repetition counter is 8 bits. No counter wraps, because each is reloaded before reuse.
- Reset asserted mid-operation: the transfer is abandoned, no done pulse is issued, and the next start begins from bit 0.
- Total transfer duration in cycles = N*PAT_W + (N-1)*GAP, where N is the effective repetition count; done follows in the next cycle.

Optional Feature:
- Macro: SEQ_TX_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 sampled in SHIFT or GAP forces the next state to DONE.
  - data_vld drops in the cycle after abort is sampled.
  - done pulses once, and the remaining repetitions are discarded.
  - abort is ignored in IDLE and DONE.
- When undefined: the abort port does not exist and transfers always run to completion.

Decomposition:
- Shared package seq_pattern_pkg contains:
  - one-hot state encoding constants (IDLE=4'b0001, SHIFT=4'b0010, GAP=4'b0100, DONE=4'b1000);
  - default pattern constant 5'b10111 and default width 5, both reused by the detector bench.
- One natural sub-module, seq_down_cnt: a loadable down-counter with a zero flag, parameterized width.
  - Instantiated three times: bit, gap and repetition counters.
- The FSM and output registers stay in the top level.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles → data=0, data_vld=0, busy=0, done=0. Release, start=0 → all outputs stay 0.
- rep_cnt=1, start pulsed at cycle 0 → cycles 1-5 carry data 1,0,1,1,1 with data_vld=1; done=1 at cycle 6 only; busy=1 on cycles 1-5.
- rep_cnt=2, GAP=2 → bits on cycles 1-5 and 8-12; cycles 6-7 have data_vld=0 and data=0; done at cycle 13.
- rep_cnt=0 → identical to rep_cnt=1. A start pulsed at cycle 3 during a transfer is ignored (no extra bits, single done).
- Reset asserted at cycle 3 of a rep_cnt=3 transfer → outputs 0 immediately and no done. A new start then gives a clean 1,0,1,1,1 on the following 5 cycles.
- Loopback into the 10111 detector with rep_cnt=4, GAP=2 → the detector output pulses exactly 4 times, one per repetition. With SEQ_TX_ABORT_EN, abort at the 2nd bit → data_vld low next cycle, one done, no detector pulse.
